fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage for the 32-bit pipeline.
- Keeps the program counter, issues single-outstanding reads to instruction memory, and presents Inst/PC/PC_plus_4 plus a valid flag to the fetch/decode pipeline register.
- Honours stall from hazard control and redirect (branch/jump/flush) from later stages, and squashes in-flight responses after a redirect.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INST, 32'h00000000, bubble instruction driven when valid=0

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  downstream cannot accept; outputs must hold
redirect  in  1  discard the fetch stream and restart at redirect_pc
redirect_pc  in  32  new fetch address (word aligned)
imem_req  out  1  read request
imem_addr  out  32  read address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid (1+ cycles after gnt)
imem_rdata  in  32  read data
Inst  out  32  fetched instruction to the decode register
PC  out  32  address of Inst
PC_plus_4  out  32  PC+4, modulo 2^32
valid  out  1  Inst/PC/PC_plus_4 meaningful

Behaviour:
- Reset, sampled on clk edge:
  - pc_q=RESET_PC; state=IDLE.
  - valid=0, Inst=NOP_INST, PC=RESET_PC, PC_plus_4=RESET_PC+4.
  - Skid buffer empty; imem_req=0.
  - rst mid-request abandons it; any later rvalid is ignored while in IDLE.
- Handoff: downstream consumes the output when valid=1 and stall=0.
  - With stall=1, Inst/PC/PC_plus_4/valid hold exactly.
  - After consumption with nothing new to present: valid=0, Inst=NOP_INST; PC/PC_plus_4 hold.
- FSM states and transitions:
  - IDLE: go to REQ next cycle.
  - REQ:
    - imem_req = !(valid && stall && skid_full); imem_addr=pc_q.
    - On imem_req && imem_gnt, go to WAIT.
    - Req and addr hold until granted, except on redirect.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid, the word goes to the output registers if the output slot is free (valid=0, or stall=0); otherwise it goes to the skid buffer.
    - The word is tagged PC=pc_q, PC_plus_4=pc_q+4; then pc_q += 4 and go to REQ.
  - DROP:
    - imem_req=0.
    - On imem_rvalid, discard the data and go to REQ.
- Skid buffer: 1 entry.
  - When the output is consumed and the skid is full, the skid entry moves to the output next edge and the skid empties.
  - Output order always equals fetch order.
- Latency: at least 2 cycles per instruction (REQ→WAIT→REQ) with zero-wait memory. Throughput is not a goal.
- Redirect (priority: rst > redirect > rvalid > stall):
  - Next edge: pc_q=redirect_pc, valid=0, Inst=NOP_INST, skid emptied.
  - Redirect clears the outputs even when stall=1.
  - Next state by current state:
    - From REQ with gnt in the same cycle: DROP.
    - From REQ without gnt: stay in REQ at the new address.
    - From WAIT without rvalid: DROP.
    - From WAIT with rvalid in the same cycle: data discarded, go to REQ.
    - From DROP without rvalid: stay in DROP with pc_q updated.
    - From DROP with rvalid in the same cycle: go to REQ.
- Arithmetic: all adds are 32-bit wrap; 32'hFFFFFFFC+4 = 0. Low 2 address bits are passed through unchecked.

Decomposition:
- Shared package fetch_pkg:
  - State enum {IDLE, REQ, WAIT, DROP}.
  - Constants: default NOP_INST, default RESET_PC.
  - Fetch-bundle struct {inst, pc, pc_plus_4}.
- One sub-module: fetch_skid_buf, a 1-entry register of the fetch bundle with load/unload/clear and a full flag.
- FSM, PC logic and output registers stay in fetch_unit.

Test Plan:
1. Reset with RESET_PC=32'h0000_0100, imem_gnt=1, 1-cycle rvalid returning 32'hAAAA0001/32'hAAAA0002 → imem_addr 0x100 then 0x104; outputs PC=0x100, PC_plus_4=0x104, then PC=0x104; valid pulses once per word.
2. Hold stall=1 from the first valid, second word returns while stalled → first bundle holds; second goes to skid; imem_req=0 afterwards. Release stall → 0x100 consumed, then 0x104 presented next cycle, in order.
3. Redirect to 32'h0000_0200 one cycle after gnt, rvalid 3 cycles later → response dropped, valid=0, next imem_addr=0x200. First valid output has PC=0x200.
4. Redirect coincident with rvalid in WAIT with stall=1 → outputs become NOP_INST, valid=0; skid empty; next request at redirect_pc.
5. RESET_PC=32'hFFFF_FFFC → PC_plus_4=0; second fetch address 0x0000_0000.
6. Assert rst while in WAIT, then a late rvalid arrives → ignored; outputs stay at reset values; fresh request at RESET_PC after IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
  } fetch_bundle_t;

  // Tag an instruction word with its address and the wrapped sequential successor.
  function automatic fetch_bundle_t make_bundle(input logic [31:0] word, input logic [31:0] addr);
    fetch_bundle_t b;
    b.inst      = word;
    b.pc        = addr;
    b.pc_plus_4 = addr + 32'd4;
    return b;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetch bundle that arrived while the output was stalled.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          unload,
  input  logic          clear,
  input  fetch_bundle_t din,
  output fetch_bundle_t dout,
  output logic          full
);

  fetch_bundle_t data_q;

  // Occupancy flag: a load wins over a same-cycle unload so a refill is never lost.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // Payload only; meaningless while full is low.
  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= din;
    end
  end

  assign dout = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem reads, skid-buffered output to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Inst,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic        valid
);

  fetch_state_e  state_q;
  logic [31:0]   pc_q;
  fetch_bundle_t out_q;
  logic          valid_q;

  fetch_bundle_t skid_dout;
  fetch_bundle_t rsp_bundle;
  logic          skid_full;
  logic          skid_load;
  logic          skid_unload;
  logic          consume;
  logic          slot_free;
  logic          rsp_accept;
  logic          grant;

  assign consume    = valid_q && !stall;
  assign slot_free  = !valid_q || !stall;
  assign rsp_accept = (state_q == WAIT) && imem_rvalid && !redirect;
  assign rsp_bundle = make_bundle(imem_rdata, pc_q);

  // Park the response when the output cannot take it, or when the skid is draining into the output.
  assign skid_load   = rsp_accept && (!slot_free || skid_full);
  assign skid_unload = consume && skid_full;

  // No new request while both the output and the skid are occupied and stalled.
  assign imem_req  = (state_q == REQ) && !(valid_q && stall && skid_full);
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (redirect),
    .din    (rsp_bundle),
    .dout   (skid_dout),
    .full   (skid_full)
  );

  // Fetch FSM and program counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          if (redirect) pc_q <= redirect_pc;
        end
        REQ: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            state_q <= grant ? DROP : REQ;
          end else if (grant) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            state_q <= imem_rvalid ? REQ : DROP;
          end else if (imem_rvalid) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= REQ;
          end
        end
        DROP: begin
          if (redirect) pc_q <= redirect_pc;
          if (imem_rvalid) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output register toward decode: skid entry first, then a fresh response, else a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= make_bundle(NOP_INST, RESET_PC);
    end else if (redirect) begin
      valid_q    <= 1'b0;
      out_q.inst <= NOP_INST;
    end else if (slot_free) begin
      if (skid_full) begin
        valid_q <= 1'b1;
        out_q   <= skid_dout;
      end else if (rsp_accept) begin
        valid_q <= 1'b1;
        out_q   <= rsp_bundle;
      end else if (consume) begin
        valid_q    <= 1'b0;
        out_q.inst <= NOP_INST;
      end
    end
  end

  assign Inst      = out_q.inst;
  assign PC        = out_q.pc;
  assign PC_plus_4 = out_q.pc_plus_4;
  assign valid     = valid_q;

endmodule
